// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C command arbiter and related
// shared-bus controllers.
package i2c_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  // Arbiter sequencing: pick a winner, launch the master, wait, answer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Counter width able to hold TIMEOUT-1; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  // Index width for a requester number; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first asserted request searching
// upward from the position just after the previous winner, wrapping.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk last+1 .. last+N_REQ (mod N_REQ); the first hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one byte-level I2C master between N_REQ requesters: round-robin
// grant, start/complete/timeout sequencing, response routed to the winner.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     m_start,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_nack
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [N_REQ-1:0]  grant_oh;

  // Unpacked views of the per-requester command fields.
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign pick_oh  = N_REQ'(1) << pick_idx;
  assign grant_oh = N_REQ'(1) << grant;

  // The terminal test looks at the post-increment value so the response
  // lands exactly TIMEOUT cycles after the start pulse.
  assign cnt_nxt = cnt + 1'b1;

  // The start pulse must follow m_busy in the same cycle, so it is the one
  // output decoded from state rather than registered.
  assign m_start = (state == ISSUE) && !m_busy;

  // Arbitration / sequencing FSM with registered handshake and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IDX_LAST;
      cnt         <= '0;
      m_rw        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            m_rw      <= req_rw[pick_idx];
            m_addr    <= addr_arr[pick_idx];
            m_wdata   <= wdata_arr[pick_idx];
            req_ready <= pick_oh;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (m_done) begin
            // A completion beats a coincident terminal count.
            rsp_valid <= grant_oh;
            rsp_rdata <= (m_rw && !m_nack) ? m_rdata : '0;
            rsp_err   <= m_nack;
            state     <= RESP;
          end else if (cnt_nxt == CNT_LAST) begin
            rsp_valid   <= grant_oh;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: directed scenarios plus a randomized run,
// all checked cycle by cycle against a transaction-level model.
module tb_i2c_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_rw = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, rsp_timeout, m_start, m_rw;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [DW-1:0]   m_rdata = '0;

  i2c_cmd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .m_start(m_start), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_rdata(m_rdata), .m_nack(m_nack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [IW-1:0] k;
    k = i[IW-1:0];
    return v[k];
  endfunction

  // Stimulus knobs and master-side model.
  bit   hold = 0, rnd_req = 0, rnd_mst = 0, rnd_busy = 0, force_busy = 0;
  int   plan_d = 3;
  bit   plan_nack = 0, plan_nodone = 0;
  logic [DW-1:0] plan_rdata = '0;
  bit   mst_run = 0;
  int   mst_cnt = 0;
  logic [N-1:0] rdy_seen = '0;
  bit   start_seen = 0;

  // Event logs.
  int rdy_idx_q[$], rdy_cyc_q[$], st_cyc_q[$], st_addr_q[$], st_wd_q[$], st_rw_q[$];
  int rsp_idx_q[$], rsp_cyc_q[$], rsp_dat_q[$], rsp_err_q[$], rsp_to_q[$];

  // Transaction-level reference: who holds the master, and how far along.
  bit   mdl_act = 0, mdl_fresh = 0, mdl_started = 0, mdl_have = 0;
  int   mdl_g = 0, mdl_last = N - 1, mdl_waited = 0;
  logic [DW-1:0] mdl_rd = '0;
  bit   mdl_er = 0, mdl_to = 0;
  logic [AW+DW:0] mdl_cmd = '0;
  logic [N-1:0] e_rdy, e_rv;
  logic e_st, e_er, e_to;
  logic [DW-1:0] e_rd;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (bitof(r, (last + k) % N)) return (last + k) % N;
    return 0;
  endfunction

  // Per-cycle compare against the model, then event logging.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                                m_start, m_rw, m_addr, m_wdata}), 64'(0));
      mdl_act = 0; mdl_fresh = 0; mdl_started = 0; mdl_have = 0;
      mdl_last = N - 1; mdl_cmd = '0;
      rdy_seen = '0; start_seen = 0;
    end else begin
      chk("m_cmd_held", 64'({m_rw, m_addr, m_wdata}), 64'(mdl_cmd));
      e_rdy = '0; e_rv = '0; e_st = 0; e_er = 0; e_to = 0; e_rd = '0;
      if (!mdl_act) begin
        if (req_valid != '0) begin
          mdl_g = rr_pick(req_valid, mdl_last);
          mdl_act = 1; mdl_fresh = 1; mdl_started = 0; mdl_have = 0;
          mdl_cmd = {bitof(req_rw, mdl_g), AW'(req_addr >> (mdl_g * AW)),
                     DW'(req_wdata >> (mdl_g * DW))};
        end
      end else if (mdl_have) begin
        e_rv = N'(1) << mdl_g; e_rd = mdl_rd; e_er = mdl_er; e_to = mdl_to;
        mdl_act = 0; mdl_last = mdl_g;
      end else if (!mdl_started) begin
        if (mdl_fresh) e_rdy = N'(1) << mdl_g;
        mdl_fresh = 0;
        if (!m_busy) begin e_st = 1; mdl_started = 1; mdl_waited = 0; end
      end else begin
        mdl_waited++;
        if (m_done) begin
          mdl_have = 1; mdl_er = m_nack; mdl_to = 0;
          mdl_rd = (mdl_cmd[AW+DW] && !m_nack) ? m_rdata : '0;
        end else if (mdl_waited == TO - 1) begin
          mdl_have = 1; mdl_er = 1; mdl_to = 1; mdl_rd = '0;
        end
      end
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("m_start", 64'(m_start), 64'(e_st));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({e_rd, e_er, e_to}));
      for (int i = 0; i < N; i++) begin
        if (bitof(req_ready, i)) begin
          rdy_idx_q.push_back(i); rdy_cyc_q.push_back(cyc);
          rdy_seen = rdy_seen | (N'(1) << i);
        end
        if (bitof(rsp_valid, i)) begin
          rsp_idx_q.push_back(i); rsp_cyc_q.push_back(cyc);
          rsp_dat_q.push_back(int'(rsp_rdata));
          rsp_err_q.push_back(int'(rsp_err)); rsp_to_q.push_back(int'(rsp_timeout));
        end
      end
      if (m_start) begin
        st_cyc_q.push_back(cyc); st_addr_q.push_back(int'(m_addr));
        st_wd_q.push_back(int'(m_wdata)); st_rw_q.push_back(int'(m_rw));
        start_seen = 1;
      end
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = req_valid | (N'(1) << i);
    req_rw    = (req_rw & ~(N'(1) << i)) | (N'(rw) << i);
    req_addr  = (req_addr & ~((N*AW)'({AW{1'b1}}) << (i*AW))) | ((N*AW)'(a) << (i*AW));
    req_wdata = (req_wdata & ~((N*DW)'({DW{1'b1}}) << (i*DW))) | ((N*DW)'(d) << (i*DW));
  endtask

  task automatic set_busy(input bit b);
    force_busy = b;
    m_busy = mst_run || force_busy;
  endtask

  // One clock: update requesters and the master model just after the edge.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (bitof(rdy_seen, i)) begin
        rdy_seen = rdy_seen & ~(N'(1) << i);
        if (!hold) req_valid = req_valid & ~(N'(1) << i);
      end
      if (rnd_req && !bitof(req_valid, i) && $urandom_range(0, 3) == 0)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end
    if (rnd_busy) force_busy = ($urandom_range(0, 3) == 0);
    m_done = 0; m_nack = 0; m_rdata = '0;
    if (start_seen) begin
      start_seen = 0;
      if (rnd_mst) begin
        plan_d = $urandom_range(1, 80);
        plan_nack = ($urandom_range(0, 3) == 0);
        plan_nodone = ($urandom_range(0, 7) == 0);
        plan_rdata = DW'($urandom);
      end
      mst_run = 1; mst_cnt = plan_d;
    end
    if (mst_run) begin
      mst_cnt--;
      if (mst_cnt <= 0) begin
        mst_run = 0;
        if (!plan_nodone) begin m_done = 1; m_nack = plan_nack; m_rdata = plan_rdata; end
      end
    end
    m_busy = mst_run || force_busy;
  endtask

  task automatic wait_rsp(input int n, input int limit, input string nm);
    int k = 0;
    while (rsp_idx_q.size() < n && k < limit) begin tick(); k++; end
    if (rsp_idx_q.size() < n) chk({nm, "_no_response"}, 64'(rsp_idx_q.size()), 64'(n));
  endtask

  task automatic chk_rsp(input string nm, input int b, input int idx, input int dat,
                         input int err, input int tmo);
    if (rsp_idx_q.size() > b) begin
      chk({nm, "_idx"}, 64'(rsp_idx_q[b]), 64'(idx));
      chk({nm, "_rdata"}, 64'(rsp_dat_q[b]), 64'(dat));
      chk({nm, "_err"}, 64'(rsp_err_q[b]), 64'(err));
      chk({nm, "_timeout"}, 64'(rsp_to_q[b]), 64'(tmo));
    end
  endtask

  task automatic chk_lat(input string nm, input int rb, input int sb, input int lat);
    if (rsp_cyc_q.size() > rb && st_cyc_q.size() > sb)
      chk({nm, "_latency"}, 64'(rsp_cyc_q[rb] - st_cyc_q[sb]), 64'(lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, sb, rb, t0, k;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_state", 64'({req_ready, rsp_valid, m_start, m_addr}), 64'(0));

    // Fairness: everyone holds valid; grants rotate from requester 0.
    hold = 1; plan_d = 3;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(7'h10 + i), DW'(8'h20 + i));
    b = rsp_idx_q.size(); rb = rdy_idx_q.size(); sb = st_cyc_q.size();
    wait_rsp(b + 6, 300, "fair");
    hold = 0; req_valid = '0; rdy_seen = '0;
    for (int j = 0; j < 6; j++)
      chk("fair_order", 64'((rb + j < rdy_idx_q.size()) ? rdy_idx_q[rb + j] : -1), 64'(j % 4));
    chk("fair_starts", 64'(st_cyc_q.size() - sb), 64'(6));

    // Single write, completion 40 cycles after start.
    plan_d = 40; b = rsp_idx_q.size(); sb = st_cyc_q.size(); rb = rdy_idx_q.size();
    t0 = cyc + 1;
    set_req(0, 1'b0, 7'h50, 8'hAB);
    wait_rsp(b + 1, 100, "wr");
    if (st_cyc_q.size() > sb && rdy_cyc_q.size() > rb) begin
      chk("wr_ready_cycle", 64'(rdy_cyc_q[rb]), 64'(t0 + 1));
      chk("wr_start_cycle", 64'(st_cyc_q[sb]), 64'(t0 + 1));
      chk("wr_m_addr", 64'(st_addr_q[sb]), 64'(7'h50));
      chk("wr_m_wdata", 64'(st_wd_q[sb]), 64'(8'hAB));
    end
    chk("wr_start_count", 64'(st_cyc_q.size() - sb), 64'(1));
    chk_rsp("wr", b, 0, 0, 0, 0);
    chk_lat("wr", b, sb, 41);

    // Single read from requester 2.
    plan_d = 5; plan_rdata = 8'hAB; b = rsp_idx_q.size();
    set_req(2, 1'b1, 7'h21, 8'h00);
    wait_rsp(b + 1, 100, "rd");
    chk_rsp("rd", b, 2, 8'hAB, 0, 0);

    // Slave NACK on a read: data forced to zero.
    plan_d = 3; plan_nack = 1; plan_rdata = 8'h5A; b = rsp_idx_q.size();
    set_req(1, 1'b1, 7'h33, 8'h11);
    wait_rsp(b + 1, 100, "nack");
    plan_nack = 0;
    chk_rsp("nack", b, 1, 0, 1, 0);

    // Master never completes: timeout exactly TO cycles after start.
    plan_nodone = 1; b = rsp_idx_q.size(); sb = st_cyc_q.size();
    set_req(3, 1'b0, 7'h44, 8'h77);
    wait_rsp(b + 1, 200, "tmo");
    plan_nodone = 0;
    chk_rsp("tmo", b, 3, 0, 1, 1);
    chk_lat("tmo", b, sb, TO);

    // Master busy at grant: start held back until busy drops.
    plan_d = 2; b = rsp_idx_q.size(); sb = st_cyc_q.size(); rb = rdy_idx_q.size();
    set_busy(1);
    set_req(0, 1'b0, 7'h12, 8'h34);
    repeat (6) tick();
    chk("busy_no_start", 64'(st_cyc_q.size() - sb), 64'(0));
    chk("busy_ready_seen", 64'(rdy_idx_q.size() - rb), 64'(1));
    t0 = cyc + 1;
    set_busy(0);
    wait_rsp(b + 1, 100, "busy");
    if (st_cyc_q.size() > sb) chk("busy_start_cycle", 64'(st_cyc_q[sb]), 64'(t0));

    // Completion on the terminal-count cycle counts as a normal finish.
    plan_d = TO - 1; plan_rdata = 8'h3C; b = rsp_idx_q.size(); sb = st_cyc_q.size();
    set_req(2, 1'b1, 7'h2C, 8'h00);
    wait_rsp(b + 1, 200, "coin");
    chk_rsp("coin", b, 2, 8'h3C, 0, 0);
    chk_lat("coin", b, sb, TO);

    // Reset while waiting: outputs drop at once, late done ignored,
    // priority returns to requester 0.
    plan_d = 2; b = rsp_idx_q.size();
    set_req(0, 1'b0, 7'h01, 8'h02);
    wait_rsp(b + 1, 100, "pre_rst");
    plan_d = 20; b = rsp_idx_q.size(); sb = st_cyc_q.size();
    set_req(1, 1'b1, 7'h05, 8'h06);
    k = 0;
    while (st_cyc_q.size() == sb && k < 50) begin tick(); k++; end
    chk("rst_txn_started", 64'(st_cyc_q.size() - sb), 64'(1));
    repeat (8) tick();
    rst = 1; #1;
    chk("rst_mid_zero", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                             m_start, m_rw, m_addr, m_wdata}), 64'(0));
    tick(); tick();
    rst = 0;
    repeat (30) tick();
    chk("rst_no_rsp", 64'(rsp_idx_q.size() - b), 64'(0));
    plan_d = 3; rb = rdy_idx_q.size();
    set_req(1, 1'b0, 7'h0A, 8'h0B);
    set_req(0, 1'b0, 7'h0C, 8'h0D);
    wait_rsp(b + 2, 100, "post_rst");
    chk("post_rst_first", 64'((rdy_idx_q.size() > rb) ? rdy_idx_q[rb] : -1), 64'(0));
    chk("post_rst_second", 64'((rdy_idx_q.size() > rb + 1) ? rdy_idx_q[rb + 1] : -1), 64'(1));

    // Randomized traffic against the model, then drain.
    rnd_req = 1; rnd_mst = 1; rnd_busy = 1;
    repeat (3000) tick();
    rnd_req = 0; rnd_busy = 0; set_busy(0);
    k = 0;
    while ((req_valid != '0 || mdl_act) && k < 1000) begin tick(); k++; end
    chk("drain_idle", 64'({req_valid, mdl_act}), 64'(0));
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
